rf_port_scheduler: RTL and testbench
====================================

// Module: rf_port_scheduler
// PURPOSE
//   Shares one single-port 16 x DW register file between two requesters: the Rd-field requester (bank 2'b11) and the Rp-field requester (bank 2'b10).
//   Extends each 2-bit field to a 4-bit file address, arbitrates round-robin and returns read data with valid one cycle after grant.
//   Sits between instruction decode and the register storage. The storage array is inside this block.
// PARAMETERS
//   DW        8   data width of each register
//   RST_VAL   0   value loaded into all 16 registers on reset
// PORTS
//   clk        in   1    single clock, rising edge
//   rst_n      in   1    asynchronous, active-low reset
//   rd_req     in   1    Rd requester: access request, held until rd_gnt
//   rd_we      in   1    Rd requester: 1 = write, 0 = read
//   rd_sel     in   2    Rd register field; file addr = {2'b11, rd_sel}
//   rd_wdata   in   DW   Rd write data
//   rd_gnt     out  1    Rd grant, 1-cycle pulse
//   rd_rvalid  out  1    Rd read data valid, 1-cycle pulse
//   rd_rdata   out  DW   Rd read data
//   rp_req/rp_we/rp_sel/rp_wdata/rp_gnt/rp_rvalid/rp_rdata: same as rd_*, file addr = {2'b10, rp_sel}
//   busy       out  1    1 while any req is pending or a response is in flight
// BEHAVIOUR
//   - Reset (async, rst_n=0): all gnt/rvalid = 0, rdata = 0, busy = 0, all 16 registers = RST_VAL, rr_ptr = RD (Rd wins first conflict).
//   - FSM per cycle (registered): IDLE -> ACCESS when any req = 1. ACCESS -> ACCESS while a req remains. ACCESS -> IDLE when no req.
//   - At most one access per cycle. Throughput is 1 access/cycle.
//   - Arbitration (combinational on sampled req):
//       - One req only: that requester is granted.
//       - Both: grant the requester named by rr_ptr. After any grant, rr_ptr points to the other requester.
//   - gnt is asserted in the same cycle the access is performed. The requester drops req (or presents its next request) on the following edge.
//   - Write: on the gnt edge, mem[addr] <= wdata. No response pulse.
//   - Read: mem[addr] is sampled on the gnt edge. rvalid = 1 and rdata are valid in the next cycle (latency 1). rdata holds its value until the next read by that requester.
//   - Read-after-write, same cycle: impossible (one access per cycle).
//   - Read-after-write, next cycle: the read returns the newly written value.
//   - A requester never receives a grant while its own rvalid is pending, unless a new req is already presented. Back-to-back reads by one requester are allowed.
//   - Unused addresses 4'b0000..4'b0111 are never accessed and keep RST_VAL.
//   - Reset mid-operation: a pending rvalid is dropped, rr_ptr returns to RD, and contents return to RST_VAL. No grant may appear in the cycle rst_n deasserts.
//   - busy = |{rd_req, rp_req, rd_rvalid, rp_rvalid}, registered version of the previous cycle OR current req.
// CONFIGURATION
//   RF_SCHED_STATS_EN defined:
//     - Adds output conflict_cnt [7:0]: increments by 1 each cycle both reqs are high. Saturates at 8'hFF. Reset to 0.
//     - Adds input stats_clr: synchronous clear, takes priority over the increment.
//   Not defined: those ports do not exist. Arbitration and timing are identical.
// TESTING
//   1. Reset: rst_n=0 for 3 cycles, then read rd_sel=2'b01 -> rd_rvalid=1 the cycle after rd_gnt, rd_rdata=RST_VAL.
//   2. Write then read: rd_we=1 sel=2 wdata=8'hA5, then rd read sel=2 next cycle -> rd_rdata=8'hA5. A rp read of sel=2 returns RST_VAL (different bank).
//   3. Conflict: both req held 4 cycles as reads -> grants alternate RD, RP, RD, RP. Each rvalid lags its gnt by 1 cycle. conflict_cnt=4 when STATS_EN.
//   4. Single requester streaming: rp_req held 5 cycles reading sel=0..3,0 -> 5 consecutive rp_gnt, 5 consecutive rp_rvalid with the matching data.
//   5. Reset mid-read: assert rst_n=0 in the cycle after rd_gnt -> rd_rvalid=0 immediately. After release, the first conflict grants RD.
//   6. STATS saturation (RF_SCHED_STATS_EN): 300 conflict cycles -> conflict_cnt=8'hFF. stats_clr=1 -> 0 next cycle.

Source files
------------

// File: rtl/rf_port_scheduler_if.sv
// Requester-side handshake bundle for one port of rf_port_scheduler.
// The requester drives req/we/sel/wdata. The scheduler answers with gnt/rvalid/rdata.
interface rf_port_if #(
  parameter int DW = 8
);
  logic          req;
  logic          we;
  logic [1:0]    sel;
  logic [DW-1:0] wdata;
  logic          gnt;
  logic          rvalid;
  logic [DW-1:0] rdata;

  modport master (output req, we, sel, wdata, input  gnt, rvalid, rdata);
  modport slave  (input  req, we, sel, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/rf_port_scheduler.sv
// Round-robin scheduler sharing a 16 x DW register file between the Rd (bank 3) and Rp (bank 2) requesters.
// Optional conflict statistics (conflict_cnt, stats_clr) exist only when RF_SCHED_STATS_EN is defined.
module rf_port_scheduler #(
  parameter int            DW      = 8,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  rf_port_if.slave    rd_port,
  rf_port_if.slave    rp_port,
`ifdef RF_SCHED_STATS_EN
  input  logic        stats_clr,
  output logic [7:0]  conflict_cnt,
`endif
  output logic        busy
);

  typedef enum logic [1:0] {S_WAKE, S_IDLE, S_ACCESS} state_t;
  localparam logic PTR_RD = 1'b0;
  localparam logic PTR_RP = 1'b1;

  state_t        state_q, state_d;
  logic          rr_ptr_q, rr_ptr_d;
  logic          rd_rvalid_q, rd_rvalid_d;
  logic          rp_rvalid_q, rp_rvalid_d;
  logic [DW-1:0] rd_rdata_q, rd_rdata_d;
  logic [DW-1:0] rp_rdata_q, rp_rdata_d;
  logic [DW-1:0] mem_q [16];

  logic          any_req;
  logic          grant_en;
  logic          gnt_rd, gnt_rp;
  logic          acc_wr;
  logic [3:0]    acc_addr;
  logic [DW-1:0] acc_wdata;
  logic [DW-1:0] mem_rd_val;

  assign any_req = rd_port.req | rp_port.req;

  // State register. S_WAKE is the state out of reset and blocks grants for one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_WAKE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAKE:   state_d = any_req ? S_ACCESS : S_IDLE;
      S_IDLE:   state_d = any_req ? S_ACCESS : S_IDLE;
      S_ACCESS: state_d = any_req ? S_ACCESS : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_en = (state_q != S_WAKE);
    gnt_rd   = grant_en & rd_port.req & (~rp_port.req | (rr_ptr_q == PTR_RD));
    gnt_rp   = grant_en & rp_port.req & (~rd_port.req | (rr_ptr_q == PTR_RP));
  end

  // Access mux: at most one of gnt_rd/gnt_rp is set, so the winner owns the file this cycle.
  always_comb begin
    acc_wr    = 1'b0;
    acc_addr  = 4'd0;
    acc_wdata = '0;
    rr_ptr_d  = rr_ptr_q;
    if (gnt_rd) begin
      acc_wr    = rd_port.we;
      acc_addr  = {2'b11, rd_port.sel};
      acc_wdata = rd_port.wdata;
      rr_ptr_d  = PTR_RP;
    end else if (gnt_rp) begin
      acc_wr    = rp_port.we;
      acc_addr  = {2'b10, rp_port.sel};
      acc_wdata = rp_port.wdata;
      rr_ptr_d  = PTR_RD;
    end
  end

  assign mem_rd_val = mem_q[acc_addr];

  always_comb begin
    rd_rvalid_d = gnt_rd & ~rd_port.we;
    rp_rvalid_d = gnt_rp & ~rp_port.we;
    rd_rdata_d  = rd_rvalid_d ? mem_rd_val : rd_rdata_q;
    rp_rdata_d  = rp_rvalid_d ? mem_rd_val : rp_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= PTR_RD;
      rd_rvalid_q <= 1'b0;
      rp_rvalid_q <= 1'b0;
      rd_rdata_q  <= '0;
      rp_rdata_q  <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      rd_rvalid_q <= rd_rvalid_d;
      rp_rvalid_q <= rp_rvalid_d;
      rd_rdata_q  <= rd_rdata_d;
      rp_rdata_q  <= rp_rdata_d;
    end
  end

  // The file must return to RST_VAL on reset, so it is built from flops, not block RAM.
  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_mem
      logic [DW-1:0] mem_d;
      always_comb begin
        mem_d = mem_q[gi];
        if (acc_wr && (acc_addr == 4'(gi))) mem_d = acc_wdata;
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem_q[gi] <= RST_VAL;
        else        mem_q[gi] <= mem_d;
      end
    end
  endgenerate

`ifdef RF_SCHED_STATS_EN
  logic [7:0] conflict_cnt_q, conflict_cnt_d;

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (stats_clr)
      conflict_cnt_d = 8'd0;
    else if (rd_port.req && rp_port.req && (conflict_cnt_q != 8'hFF))
      conflict_cnt_d = conflict_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) conflict_cnt_q <= 8'd0;
    else        conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

  assign rd_port.gnt    = gnt_rd;
  assign rp_port.gnt    = gnt_rp;
  assign rd_port.rvalid = rd_rvalid_q;
  assign rp_port.rvalid = rp_rvalid_q;
  assign rd_port.rdata  = rd_rdata_q;
  assign rp_port.rdata  = rp_rdata_q;
  assign busy           = any_req | rd_rvalid_q | rp_rvalid_q;

endmodule

// File: tb/tb_rf_port_scheduler.sv
// Directed self-checking bench for rf_port_scheduler; stats checks compile in with RF_SCHED_STATS_EN.
module tb_rf_port_scheduler;
  localparam int            DW   = 8;
  localparam logic [DW-1:0] RSTV = 8'h3C;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   total = 0;
  int   bad = 0;

  rf_port_if #(.DW(DW)) rd_bus ();
  rf_port_if #(.DW(DW)) rp_bus ();

`ifdef RF_SCHED_STATS_EN
  logic       stats_clr = 1'b0;
  logic [7:0] conflict_cnt;
`endif

  rf_port_scheduler #(.DW(DW), .RST_VAL(RSTV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_port      (rd_bus),
    .rp_port      (rp_bus),
`ifdef RF_SCHED_STATS_EN
    .stats_clr    (stats_clr),
    .conflict_cnt (conflict_cnt),
`endif
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic set_rd(input logic req, input logic we, input logic [1:0] sel, input logic [7:0] wd);
    rd_bus.req = req; rd_bus.we = we; rd_bus.sel = sel; rd_bus.wdata = wd;
  endtask

  task automatic set_rp(input logic req, input logic we, input logic [1:0] sel, input logic [7:0] wd);
    rp_bus.req = req; rp_bus.we = we; rp_bus.sel = sel; rp_bus.wdata = wd;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] stream_sel [5];
  logic [7:0] stream_exp [5];

  initial begin
    stream_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    stream_exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    set_rd(0, 0, 0, 0);
    set_rp(0, 0, 0, 0);

    // Reset values
    @(negedge clk);
    chk("rst_rd_gnt", rd_bus.gnt, 0);
    chk("rst_rd_rvalid", rd_bus.rvalid, 0);
    chk("rst_rd_rdata", rd_bus.rdata, 0);
    chk("rst_rp_rdata", rp_bus.rdata, 0);
    chk("rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;

    // Test 1: no grant in the release cycle, then a read returns RST_VAL
    rst_n = 1'b1;
    set_rd(1, 0, 1, 0);
    @(negedge clk); chk("wake_no_gnt", rd_bus.gnt, 0);
    next_cycle();
    @(negedge clk); chk("t1_gnt", rd_bus.gnt, 1); chk("t1_rv_early", rd_bus.rvalid, 0);
    next_cycle();
    set_rd(0, 0, 0, 0);
    @(negedge clk); chk("t1_rvalid", rd_bus.rvalid, 1); chk("t1_rdata", rd_bus.rdata, RSTV);
    next_cycle();

    // Test 2: write then read-after-write on Rd, then Rp reads other bank
    set_rd(1, 1, 2, 8'hA5);
    @(negedge clk); chk("t2_wr_gnt", rd_bus.gnt, 1); chk("t2_prev_rv_drop", rd_bus.rvalid, 0);
    next_cycle();
    set_rd(1, 0, 2, 0);
    @(negedge clk); chk("t2_wr_no_rv", rd_bus.rvalid, 0); chk("t2_rd_gnt", rd_bus.gnt, 1);
    next_cycle();
    set_rd(0, 0, 0, 0);
    set_rp(1, 0, 2, 0);
    @(negedge clk);
    chk("t2_raw_rv", rd_bus.rvalid, 1); chk("t2_raw_data", rd_bus.rdata, 8'hA5);
    chk("t2_rp_gnt", rp_bus.gnt, 1);
    next_cycle();
    set_rp(0, 0, 0, 0);
    @(negedge clk);
    chk("t2_rp_data", rp_bus.rdata, RSTV); chk("t2_rp_rv", rp_bus.rvalid, 1);
    chk("t2_rd_hold", rd_bus.rdata, 8'hA5); chk("t2_rd_rv_pulse", rd_bus.rvalid, 0);
    next_cycle();

    // Load Rp bank with 10..13 by streaming writes
    for (int i = 0; i < 4; i++) begin
      set_rp(1, 1, 2'(i), 8'h10 + 8'(i));
      @(negedge clk); chk($sformatf("ld_gnt%0d", i), rp_bus.gnt, 1);
      next_cycle();
    end
    set_rp(0, 0, 0, 0);
    @(negedge clk); chk("ld_no_rv", rp_bus.rvalid, 0); chk("idle_busy", busy, 0);
    next_cycle();

    // Test 3: 4 conflict cycles alternate RD, RP, RD, RP
    set_rd(1, 0, 2, 0);
    set_rp(1, 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        set_rd(0, 0, 0, 0);
        set_rp(0, 0, 0, 0);
      end
      @(negedge clk);
      chk($sformatf("t3_rd_gnt%0d", i), rd_bus.gnt, (i < 4 && i % 2 == 0) ? 1 : 0);
      chk($sformatf("t3_rp_gnt%0d", i), rp_bus.gnt, (i < 4 && i % 2 == 1) ? 1 : 0);
      chk($sformatf("t3_rd_rv%0d", i), rd_bus.rvalid, (i % 2 == 1) ? 1 : 0);
      chk($sformatf("t3_rp_rv%0d", i), rp_bus.rvalid, (i > 0 && i % 2 == 0) ? 1 : 0);
      if (i == 1) chk("t3_rd_data", rd_bus.rdata, 8'hA5);
      if (i == 2) chk("t3_rp_data", rp_bus.rdata, 8'h11);
`ifdef RF_SCHED_STATS_EN
      if (i == 4) chk("t3_conflict_cnt", conflict_cnt, 4);
`endif
      next_cycle();
    end

    // Test 4: Rp streams 5 reads back to back
    for (int i = 0; i < 6; i++) begin
      if (i < 5) set_rp(1, 0, stream_sel[i], 0);
      else       set_rp(0, 0, 0, 0);
      @(negedge clk);
      chk($sformatf("t4_gnt%0d", i), rp_bus.gnt, (i < 5) ? 1 : 0);
      chk($sformatf("t4_rv%0d", i), rp_bus.rvalid, (i > 0) ? 1 : 0);
      if (i > 0) chk($sformatf("t4_data%0d", i), rp_bus.rdata, stream_exp[i-1]);
      chk($sformatf("t4_busy%0d", i), busy, 1);
      next_cycle();
    end
    @(negedge clk); chk("t4_busy_end", busy, 0);
    next_cycle();

    // Test 5: reset right after an Rd grant edge drops the pending rvalid
    set_rd(1, 0, 2, 0);
    @(negedge clk); chk("t5_gnt", rd_bus.gnt, 1);
    next_cycle();
    rst_n = 1'b0;
    set_rd(0, 0, 0, 0);
    #1;
    chk("t5_rv_dropped", rd_bus.rvalid, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_rd(1, 0, 2, 0);
    set_rp(1, 0, 1, 0);
    @(negedge clk);
    chk("t5_wake_rd", rd_bus.gnt, 0); chk("t5_wake_rp", rp_bus.gnt, 0);
    next_cycle();
    @(negedge clk); chk("t5_first_rd", rd_bus.gnt, 1); chk("t5_first_rp", rp_bus.gnt, 0);
    next_cycle();
    set_rd(0, 0, 0, 0);
    @(negedge clk);
    chk("t5_rp_gnt", rp_bus.gnt, 1); chk("t5_rd_rstval", rd_bus.rdata, RSTV);
    next_cycle();
    set_rp(0, 0, 0, 0);
    @(negedge clk); chk("t5_rp_rstval", rp_bus.rdata, RSTV);
    next_cycle();

`ifdef RF_SCHED_STATS_EN
    // Test 6: clear beats increment, then saturation, then clear again
    set_rd(1, 0, 0, 0);
    set_rp(1, 0, 0, 0);
    stats_clr = 1'b1;
    next_cycle();
    stats_clr = 1'b0;
    @(negedge clk); chk("t6_clr_prio", conflict_cnt, 0);
    repeat (300) next_cycle();
    @(negedge clk); chk("t6_saturate", conflict_cnt, 8'hFF);
    next_cycle();
    stats_clr = 1'b1;
    next_cycle();
    stats_clr = 1'b0;
    set_rd(0, 0, 0, 0);
    set_rp(0, 0, 0, 0);
    @(negedge clk); chk("t6_clr", conflict_cnt, 0);
    next_cycle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
